pipeline_control_unit: RTL

PIPELINE_CONTROL_UNIT -- requirements
Module: pipeline_control_unit

---
 rtl/pipeline_control_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipeline_control_unit.sv
// Hazard detection, forwarding select, stage-valid tracking and commit display for an in-order pipeline.
// Build option PIPE_CTRL_FORWARD_EN enables EX/MEM/WB forwarding; otherwise any RAW hazard stalls.
module pipeline_control_unit #(
  parameter int STAGES     = 5,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [REG_ADDR_W-1:0] IdRs,
  input  logic [REG_ADDR_W-1:0] IdRt,
  input  logic                  IdUsesRt,
  input  logic                  ExRegWrite,
  input  logic                  ExMemRead,
  input  logic [REG_ADDR_W-1:0] ExWriteReg,
  input  logic                  MemRegWrite,
  input  logic [REG_ADDR_W-1:0] MemWriteReg,
  input  logic                  WbRegWrite,
  input  logic [REG_ADDR_W-1:0] WbWriteReg,
  input  logic                  RedirectD,
  input  logic                  CommitDisplay,
  input  logic                  CommitSuppress,
  input  logic [DATA_W-1:0]     CommitPC,
  input  logic [DATA_W-1:0]     CommitData,
  output logic                  PCWriteEn,
  output logic                  IfIdWriteEn,
  output logic                  IfIdFlush,
  output logic                  IdExBubble,
  output logic [1:0]            FwdA,
  output logic [1:0]            FwdB,
  output logic [STAGES-1:0]     StageValid,
  output logic [DATA_W-1:0]     PCDisplay,
  output logic [DATA_W-1:0]     WriteDataDisplay,
  output logic [CNT_W-1:0]      RetireCount,
  output logic [CNT_W-1:0]      StallCount
);

  localparam int EX_IDX  = 2;
  localparam int MEM_IDX = 3;
  localparam int WB_IDX  = STAGES - 1;

  logic [STAGES-1:0] valid_q;
  logic              ex_live, mem_live, wb_live;
  logic              ex_hit_a, ex_hit_b;
  logic              mem_hit_a, mem_hit_b;
  logic              wb_hit_a, wb_hit_b;
  logic              stall;
  logic              commit;

  // A producer only counts if its stage holds a real instruction writing a nonzero register.
  assign ex_live  = valid_q[EX_IDX]  && ExRegWrite  && (ExWriteReg  != '0);
  assign mem_live = valid_q[MEM_IDX] && MemRegWrite && (MemWriteReg != '0);
  assign wb_live  = valid_q[WB_IDX]  && WbRegWrite  && (WbWriteReg  != '0);

  assign ex_hit_a  = ex_live  && (ExWriteReg  == IdRs);
  assign ex_hit_b  = ex_live  && IdUsesRt && (ExWriteReg  == IdRt);
  assign mem_hit_a = mem_live && (MemWriteReg == IdRs);
  assign mem_hit_b = mem_live && IdUsesRt && (MemWriteReg == IdRt);
  assign wb_hit_a  = wb_live  && (WbWriteReg  == IdRs);
  assign wb_hit_b  = wb_live  && IdUsesRt && (WbWriteReg  == IdRt);

`ifdef PIPE_CTRL_FORWARD_EN
  // Youngest producer wins so the operand sees the most recent value.
  always_comb begin
    FwdA = 2'b00;
    if (ex_hit_a)       FwdA = 2'b01;
    else if (mem_hit_a) FwdA = 2'b10;
    else if (wb_hit_a)  FwdA = 2'b11;
  end

  always_comb begin
    FwdB = 2'b00;
    if (ex_hit_b)       FwdB = 2'b01;
    else if (mem_hit_b) FwdB = 2'b10;
    else if (wb_hit_b)  FwdB = 2'b11;
  end

  assign stall = ExMemRead && (ex_hit_a || ex_hit_b);
`else
  logic unused_load;

  assign unused_load = ExMemRead;
  assign FwdA        = 2'b00;
  assign FwdB        = 2'b00;
  assign stall       = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b || wb_hit_a || wb_hit_b;
`endif

  assign PCWriteEn   = !stall;
  assign IfIdWriteEn = !stall;
  assign IdExBubble  = stall;
  // Stall wins over redirect; the redirect is seen again once decode advances.
  assign IfIdFlush   = RedirectD && !stall;

  assign commit     = valid_q[WB_IDX] && CommitDisplay;
  assign StageValid = valid_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      valid_q          <= STAGES'(1);
      PCDisplay        <= '0;
      WriteDataDisplay <= '0;
      RetireCount      <= '0;
      StallCount       <= '0;
    end else begin
      valid_q[0] <= 1'b1;

      if (stall)          valid_q[1] <= valid_q[1];
      else if (IfIdFlush) valid_q[1] <= 1'b0;
      else                valid_q[1] <= valid_q[0];

      // The stalled decode slot enters EX as a bubble.
      valid_q[2]          <= stall ? 1'b0 : valid_q[1];
      valid_q[STAGES-1:3] <= valid_q[STAGES-2:2];

      if (commit) begin
        PCDisplay        <= CommitPC;
        WriteDataDisplay <= CommitSuppress ? '0 : CommitData;
        if (RetireCount != '1) RetireCount <= RetireCount + CNT_W'(1);
      end

      if (stall && (StallCount != '1)) StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule
